// File: rtl/uart_mmio_peripheral.sv
// Memory-mapped 8N1 UART: byte stores feed a TX FIFO, byte loads drain an RX FIFO.
// Optional build macro UART_LOOPBACK_EN routes internal tx into the receiver and parks the tx pin.
module uart_mmio_peripheral #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        UART_WRITE_EN,
  input  logic        UART_READ_EN,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BitEnd  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfEnd = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StTxIdle, StTxStart, StTxData, StTxStop} tx_state_e;
  typedef enum logic [1:0] {StRxIdle, StRxStart, StRxData, StRxStop} rx_state_e;

  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:8];

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_rd_q;
  logic          tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]    tx_head;

  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];
  // The FSM takes the next byte either from idle or straight out of a finishing stop bit.
  assign tx_pop   = !tx_empty &&
                    ((tx_state_q == StTxIdle) || ((tx_state_q == StTxStop) && (tx_cnt_q == BitEnd)));
  assign tx_push  = UART_WRITE_EN && (!tx_full || tx_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= WriteData[7:0];
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= StTxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      unique case (tx_state_q)
        StTxIdle: begin
          if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= StTxStart;
          end
        end
        StTxStart: begin
          if (tx_cnt_q == BitEnd) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= StTxData;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        StTxData: begin
          if (tx_cnt_q == BitEnd) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= StTxStop;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        StTxStop: begin
          if (tx_cnt_q == BitEnd) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_shift_q <= tx_head;
              tx_q       <= 1'b0;
              tx_state_q <= StTxStart;
            end else begin
              tx_state_q <= StTxIdle;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_q <= StTxIdle;
      endcase
    end
  end

  // ---------------- pin routing ----------------
  logic rx_in;
`ifdef UART_LOOPBACK_EN
  logic unused_rx;
  assign unused_rx = rx;
  assign rx_in     = tx_q;
  assign tx        = 1'b1;
`else
  assign rx_in = rx;
  assign tx    = tx_q;
`endif

  // ---------------- RX FSM ----------------
  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_armed_q;
  logic          rx_done_q;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      rx_state_q <= StRxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_armed_q <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      rx_done_q <= 1'b0;
      unique case (rx_state_q)
        StRxIdle: begin
          // Only a high-to-low transition starts a frame; a line stuck low is ignored.
          if (!rx_armed_q) begin
            rx_armed_q <= rx_s;
          end else if (!rx_s) begin
            rx_cnt_q   <= '0;
            rx_state_q <= StRxStart;
          end
        end
        StRxStart: begin
          if (rx_cnt_q == HalfEnd) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            if (rx_s) begin
              rx_armed_q <= 1'b0;
              rx_state_q <= StRxIdle;
            end else begin
              rx_state_q <= StRxData;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        StRxData: begin
          if (rx_cnt_q == BitEnd) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= StRxStop;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        StRxStop: begin
          if (rx_cnt_q == BitEnd) begin
            rx_cnt_q   <= '0;
            rx_armed_q <= 1'b0;
            rx_done_q  <= rx_s;
            rx_state_q <= StRxIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= StRxIdle;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_q, rx_rd_q;
  logic          rx_empty, rx_full, rx_push, rx_pop;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_pop   = UART_READ_EN && !rx_empty;
  assign rx_push  = rx_done_q && (!rx_full || rx_pop);
  assign ReadData = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rd_q[AW-1:0]]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_shift_q;
  end

endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// Self-checking bench for uart_mmio_peripheral: random bytes against a queue-based UART model.
// Define UART_LOOPBACK_EN for both RTL and bench to exercise the loopback build.
module tb_uart_mmio_peripheral;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        UART_WRITE_EN;
  logic        UART_READ_EN;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx;
  logic        rx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_mmio_peripheral #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .UART_WRITE_EN(UART_WRITE_EN),
    .UART_READ_EN (UART_READ_EN),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .tx           (tx),
    .rx           (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at a negedge (or immediately) once the given clock edge count is reached.
  task automatic wait_edge(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    UART_WRITE_EN = 1'b0;
    UART_READ_EN  = 1'b0;
    WriteData = '0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output int edge_n);
    WriteData = {$urandom_range(0, 32'hFF_FFFF)} << 8 | 32'(b);
    UART_WRITE_EN = 1'b1;
    @(posedge clk);
    #1;
    edge_n = cyc;
    UART_WRITE_EN = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [31:0] exp);
    check_eq(tag, ReadData, exp);
    UART_READ_EN = 1'b1;
    @(posedge clk);
    #1;
    UART_READ_EN = 1'b0;
  endtask

  task automatic count_tx_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, lows;
    logic [7:0] b;
    logic [9:0] f;
    logic [7:0] exp_q[$];
    logic [7:0] burst[DEPTH + 2];

    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq("idle_tx", tx, 1'b1);
      check_eq("idle_rd", ReadData, 32'hFFFF_FFFF);
    end
    idle(1);

`ifdef UART_LOOPBACK_EN
    // Loopback: every written byte comes back through the receiver; pin stays high.
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h5A : 8'($urandom_range(0, 255));
      write_byte(b, n);
      count_tx_low(10 * CPB + 8, lows);
      check_eq("lb_pin", lows, 0);
      idle(1);
      read_check("lb_data", {24'h0, b});
      check_eq("lb_empty", ReadData, 32'hFFFF_FFFF);
    end
    write_byte(8'($urandom_range(0, 255)), n);
    idle(10);
    #2 reset = 1'b0;
    #1;
    check_eq("lb_rst_tx", tx, 1'b1);
    check_eq("lb_rst_rd", ReadData, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;
    idle(10 * CPB + 10);
    check_eq("lb_lost", ReadData, 32'hFFFF_FFFF);
`else
    // Exact TX waveform: 0xA5 then random bytes, sampled every cycle.
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      f = {1'b1, b, 1'b0};
      write_byte(b, n);
      check_eq("tx_latency", tx, 1'b1);
      for (int i = 0; i < 10; i++) begin
        for (int s = 0; s < int'(CPB); s++) begin
          wait_edge(n + 1 + i * CPB + s);
          check_eq("tx_wave", tx, f[i]);
        end
      end
      wait_edge(n + 1 + 10 * CPB);
      check_eq("tx_after", tx, 1'b1);
      idle(3);
    end

    // Burst of DEPTH+2 writes: one leaves immediately, DEPTH buffered, the last is dropped.
    exp_q.delete();
    for (int k = 0; k < int'(DEPTH) + 2; k++) begin
      burst[k] = 8'($urandom_range(0, 255));
      if (k <= int'(DEPTH)) exp_q.push_back(burst[k]);
    end
    n = cyc + 1;
    fork
      begin
        int e;
        for (int k = 0; k < int'(DEPTH) + 2; k++) write_byte(burst[k], e);
      end
      begin
        logic [9:0] fr;
        for (int j = 0; j <= int'(DEPTH); j++) begin
          fr = {1'b1, exp_q[j], 1'b0};
          for (int i = 0; i < 10; i++) begin
            wait_edge(n + 1 + j * 10 * CPB + i * CPB + 2);
            check_eq("burst_bit", tx, fr[i]);
          end
        end
      end
    join
    count_tx_low(60, lows);
    check_eq("burst_drop", lows, 0);
    idle(1);

    // Single RX frame, then pop.
    send_frame(8'h3C, 1'b1);
    idle(6);
    read_check("rx_3c", 32'h0000_003C);
    check_eq("rx_popped", ReadData, 32'hFFFF_FFFF);

    // Framing error discards the byte; following good frame is kept.
    send_frame(8'($urandom_range(0, 255)), 1'b0);
    idle(8);
    check_eq("rx_frame_err", ReadData, 32'hFFFF_FFFF);
    send_frame(8'h81, 1'b1);
    idle(6);
    read_check("rx_81", 32'h0000_0081);
    check_eq("rx_81_empty", ReadData, 32'hFFFF_FFFF);

    // One-cycle glitch.
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(20);
    check_eq("rx_glitch", ReadData, 32'hFFFF_FFFF);

    // Random frames overflowing the RX FIFO; model keeps the first DEPTH.
    exp_q.delete();
    for (int k = 0; k < int'(DEPTH) + 4; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      idle($urandom_range(0, 3));
    end
    idle(6);
    while (exp_q.size() > 0) read_check("rx_fifo", {24'h0, exp_q.pop_front()});
    check_eq("rx_drained", ReadData, 32'hFFFF_FFFF);

    // Reset mid-frame with data queued on both sides.
    send_frame(8'($urandom_range(0, 255)), 1'b1);
    idle(6);
    check_eq("pre_rst_rd", ReadData[31:8], 24'h0);
    write_byte(8'($urandom_range(0, 255)), n);
    write_byte(8'($urandom_range(0, 255)), n);
    check_eq("pre_rst_tx", tx, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_rd", ReadData, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;
    count_tx_low(60, lows);
    check_eq("rst_lost_tx", lows, 0);
    check_eq("rst_lost_rd", ReadData, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
